// File: rtl/mips_gpio_pkg.sv
// rtl/mips_gpio_pkg.sv - shared register map, edge-select encoding and bus width for the GPIO port
package mips_gpio_pkg;

    localparam int GPIO_BUS_W = 32;

    localparam int GPIO_DATA_IN  = 0;
    localparam int GPIO_DATA_OUT = 1;
    localparam int GPIO_DIR      = 2;
    localparam int GPIO_IRQ_EN   = 3;
    localparam int GPIO_IRQ_STAT = 4;
    localparam int GPIO_EDGE_SEL = 5;

    typedef enum logic {
        EDGE_RISE = 1'b0,
        EDGE_FALL = 1'b1
    } gpio_edge_e;

endpackage

// File: rtl/gpio_in_filter.sv
// rtl/gpio_in_filter.sv - one pin: 2-flop synchroniser plus debounce counter when GPIO_DEBOUNCE_EN is defined
module gpio_in_filter
`ifdef GPIO_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = 16
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic filt
);

    logic sync1;
    logic sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CNT_W-1:0] cnt;
    logic             filt_q;

    // Accept the new level on the DEBOUNCE_CYCLES-th consecutive differing cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            filt_q <= 1'b0;
        end else if (sync2 == filt_q) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt    <= '0;
            filt_q <= sync2;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign filt = filt_q;
`else
    assign filt = sync2;
`endif

endmodule

// File: rtl/mips_gpio_port.sv
// rtl/mips_gpio_port.sv - memory-mapped GPIO: register file, bus decode, edge detect, irq
// Optional input debounce selected by defining GPIO_DEBOUNCE_EN.
module mips_gpio_port
    import mips_gpio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int ADDR_W          = 3,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     bus_addr,
    input  logic [GPIO_BUS_W-1:0] bus_wdata,
    input  logic                  bus_we,
    input  logic                  bus_re,
    output logic [GPIO_BUS_W-1:0] bus_rdata,
    input  logic [WIDTH-1:0]      gpio_i,
    output logic [WIDTH-1:0]      gpio_o,
    output logic [WIDTH-1:0]      gpio_oe,
    output logic                  irq
);

    if (WIDTH < 1 || WIDTH > GPIO_BUS_W || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
        $error("mips_gpio_port: unsupported WIDTH or DEBOUNCE_CYCLES");
    end

    logic [WIDTH-1:0]      filt;
    logic [WIDTH-1:0]      filt_q;
    logic [WIDTH-1:0]      data_out;
    logic [WIDTH-1:0]      dir;
    logic [WIDTH-1:0]      irq_en;
    logic [WIDTH-1:0]      irq_stat;
    logic [WIDTH-1:0]      edge_sel;
    logic [WIDTH-1:0]      edge_hit;
    logic [WIDTH-1:0]      w1c_mask;
    logic [WIDTH-1:0]      wr_val;
    logic [GPIO_BUS_W-1:0] rd_mux;
    logic                  unused_wdata;

    assign wr_val       = bus_wdata[WIDTH-1:0];
    assign unused_wdata = ^bus_wdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        gpio_in_filter
`ifdef GPIO_DEBOUNCE_EN
            #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
            u_filter (
                .clk  (clk),
                .rst  (rst),
                .pin  (gpio_i[i]),
                .filt (filt[i])
            );
    end

    // Compares filt with its own previous value only, so an EDGE_SEL write cannot fake an edge.
    always_comb begin
        edge_hit = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (gpio_edge_e'(edge_sel[i]) == EDGE_FALL)
                edge_hit[i] = filt_q[i] & ~filt[i];
            else
                edge_hit[i] = filt[i] & ~filt_q[i];
        end
    end

    always_comb begin
        w1c_mask = '0;
        if (bus_we && bus_addr == ADDR_W'(GPIO_IRQ_STAT))
            w1c_mask = wr_val;
    end

    always_comb begin
        rd_mux = '0;
        case (bus_addr)
            ADDR_W'(GPIO_DATA_IN):  rd_mux = GPIO_BUS_W'(filt);
            ADDR_W'(GPIO_DATA_OUT): rd_mux = GPIO_BUS_W'(data_out);
            ADDR_W'(GPIO_DIR):      rd_mux = GPIO_BUS_W'(dir);
            ADDR_W'(GPIO_IRQ_EN):   rd_mux = GPIO_BUS_W'(irq_en);
            ADDR_W'(GPIO_IRQ_STAT): rd_mux = GPIO_BUS_W'(irq_stat);
            ADDR_W'(GPIO_EDGE_SEL): rd_mux = GPIO_BUS_W'(edge_sel);
            default:                rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out  <= '0;
            dir       <= '0;
            irq_en    <= '0;
            irq_stat  <= '0;
            edge_sel  <= '0;
            filt_q    <= '0;
            irq       <= 1'b0;
            bus_rdata <= '0;
        end else begin
            if (bus_we) begin
                case (bus_addr)
                    ADDR_W'(GPIO_DATA_OUT): data_out <= wr_val;
                    ADDR_W'(GPIO_DIR):      dir      <= wr_val;
                    ADDR_W'(GPIO_IRQ_EN):   irq_en   <= wr_val;
                    ADDR_W'(GPIO_EDGE_SEL): edge_sel <= wr_val;
                    default: ;
                endcase
            end
            // OR-ing the new edge after the clear makes a same-cycle set win over W1C.
            irq_stat <= (irq_stat & ~w1c_mask) | edge_hit;
            filt_q   <= filt;
            irq      <= |(irq_stat & irq_en);
            if (bus_re)
                bus_rdata <= rd_mux;
        end
    end

    assign gpio_o  = data_out;
    assign gpio_oe = dir;

endmodule

// File: tb/tb_mips_gpio_port.sv
// tb/tb_mips_gpio_port.sv - self-checking bench for mips_gpio_port (vectors, random vs model, debounce)
module tb_mips_gpio_port;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_we;
    logic        bus_re;
    logic [31:0] bus_rdata;
    logic [7:0]  gpio_i;
    logic [7:0]  gpio_o;
    logic [7:0]  gpio_oe;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_gpio_port #(
        .WIDTH           (8),
        .ADDR_W          (3),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_we    (bus_we),
        .bus_re    (bus_re),
        .bus_rdata (bus_rdata),
        .gpio_i    (gpio_i),
        .gpio_o    (gpio_o),
        .gpio_oe   (gpio_oe),
        .irq       (irq)
    );

    // Reference model: pin history p1/p2/p3 = pins seen 1/2/3 edges ago.
    logic [7:0]  m_out, m_dir, m_en, m_stat, m_sel;
    logic [7:0]  p1, p2, p3;
    logic [31:0] m_rd;
    logic        m_irq;

    typedef struct {
        logic [2:0]  a;
        logic [31:0] d;
        logic        we;
        logic        re;
        logic [7:0]  pins;
        logic [7:0]  e_o;
        logic [7:0]  e_oe;
        logic        e_irq;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_out = 0; m_dir = 0; m_en = 0; m_stat = 0; m_sel = 0;
        p1 = 0; p2 = 0; p3 = 0;
        m_rd = 0; m_irq = 0;
    endtask

    function automatic logic [7:0] m_reg_val(input logic [2:0] a);
        case (a)
            3'd0:    return p2;
            3'd1:    return m_out;
            3'd2:    return m_dir;
            3'd3:    return m_en;
            3'd4:    return m_stat;
            3'd5:    return m_sel;
            default: return 8'h00;
        endcase
    endfunction

    task automatic drive(input logic [2:0] a, input logic [31:0] d, input logic we,
                         input logic re, input logic [7:0] pins);
        logic [7:0] det;
        logic [7:0] w1c;
        bus_addr  = a;
        bus_wdata = d;
        bus_we    = we;
        bus_re    = re;
        gpio_i    = pins;
        for (int i = 0; i < 8; i++)
            det[i] = m_sel[i] ? (p3[i] && !p2[i]) : (p2[i] && !p3[i]);
        w1c = (we && a == 3'd4) ? d[7:0] : 8'h00;
        if (re) m_rd = {24'h0, m_reg_val(a)};
        m_irq  = |(m_stat & m_en);
        m_stat = (m_stat & ~w1c) | det;
        if (we) begin
            case (a)
                3'd1: m_out = d[7:0];
                3'd2: m_dir = d[7:0];
                3'd3: m_en  = d[7:0];
                3'd5: m_sel = d[7:0];
                default: ;
            endcase
        end
        p3 = p2; p2 = p1; p1 = pins;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [2:0] a, input logic [31:0] d, input logic we, input logic re,
                       input logic [7:0] pins, input logic [7:0] e_o, input logic [7:0] e_oe,
                       input logic e_irq, input logic [31:0] e_rd);
        vt.push_back('{a, d, we, re, pins, e_o, e_oe, e_irq, e_rd});
    endtask

    initial begin
        rst = 1'b1;
        bus_addr = 0; bus_wdata = 0; bus_we = 0; bus_re = 0; gpio_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_o", {24'h0, gpio_o}, 32'h0);
        chk("reset_oe", {24'h0, gpio_oe}, 32'h0);
        chk("reset_irq", {31'h0, irq}, 32'h0);
        chk("reset_rdata", bus_rdata, 32'h0);
        rst = 1'b0;

        drive(3'd2, 32'hFF, 1, 0, 8'h00);
        drive(3'd1, 32'h55, 1, 0, 8'h00);
        drive(3'd1, 32'h0, 0, 1, 8'h00);
        chk("pre_rst_rdata", bus_rdata, 32'h55);
        chk("pre_rst_o", {24'h0, gpio_o}, 32'h55);
        #3 rst = 1'b1;
        #1;
        chk("midrst_o", {24'h0, gpio_o}, 32'h0);
        chk("midrst_oe", {24'h0, gpio_oe}, 32'h0);
        chk("midrst_irq", {31'h0, irq}, 32'h0);
        chk("midrst_rdata", bus_rdata, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        for (int a = 0; a < 8; a++) begin
            drive(3'(a), 32'h0, 0, 1, 8'h00);
            chk($sformatf("post_rst_read%0d", a), bus_rdata, 32'h0);
        end

`ifndef GPIO_DEBOUNCE_EN
        //  a   data          we re pins   o      oe     irq rd
        add(2, 32'hFF,        1, 0, 8'h00, 8'h00, 8'hFF, 0, 32'h00);
        add(1, 32'hA5,        1, 0, 8'h00, 8'hA5, 8'hFF, 0, 32'h00);
        add(1, 32'h0,         0, 1, 8'h00, 8'hA5, 8'hFF, 0, 32'hA5);
        add(5, 32'h0,         1, 0, 8'h00, 8'hA5, 8'hFF, 0, 32'hA5);
        add(3, 32'h1,         1, 0, 8'h00, 8'hA5, 8'hFF, 0, 32'hA5);
        add(0, 32'h0,         0, 0, 8'h81, 8'hA5, 8'hFF, 0, 32'hA5);
        add(0, 32'h0,         0, 0, 8'h81, 8'hA5, 8'hFF, 0, 32'hA5);
        add(0, 32'h0,         0, 1, 8'h81, 8'hA5, 8'hFF, 0, 32'h81);
        add(4, 32'h0,         0, 1, 8'h81, 8'hA5, 8'hFF, 1, 32'h81);
        add(4, 32'h1,         1, 0, 8'h81, 8'hA5, 8'hFF, 1, 32'h81);
        add(4, 32'h0,         0, 1, 8'h81, 8'hA5, 8'hFF, 0, 32'h80);
        add(5, 32'h2,         1, 0, 8'h81, 8'hA5, 8'hFF, 0, 32'h80);
        add(0, 32'h0,         0, 0, 8'h83, 8'hA5, 8'hFF, 0, 32'h80);
        add(0, 32'h0,         0, 0, 8'h83, 8'hA5, 8'hFF, 0, 32'h80);
        add(0, 32'h0,         0, 0, 8'h83, 8'hA5, 8'hFF, 0, 32'h80);
        add(4, 32'h0,         0, 1, 8'h83, 8'hA5, 8'hFF, 0, 32'h80);
        add(0, 32'h0,         0, 0, 8'h81, 8'hA5, 8'hFF, 0, 32'h80);
        add(0, 32'h0,         0, 0, 8'h81, 8'hA5, 8'hFF, 0, 32'h80);
        add(0, 32'h0,         0, 0, 8'h81, 8'hA5, 8'hFF, 0, 32'h80);
        add(4, 32'h0,         0, 1, 8'h81, 8'hA5, 8'hFF, 0, 32'h82);
        add(0, 32'h0,         0, 0, 8'h80, 8'hA5, 8'hFF, 0, 32'h82);
        add(0, 32'h0,         0, 0, 8'h80, 8'hA5, 8'hFF, 0, 32'h82);
        add(0, 32'h0,         0, 0, 8'h80, 8'hA5, 8'hFF, 0, 32'h82);
        add(0, 32'h0,         0, 0, 8'h81, 8'hA5, 8'hFF, 0, 32'h82);
        add(0, 32'h0,         0, 0, 8'h81, 8'hA5, 8'hFF, 0, 32'h82);
        add(4, 32'h1,         1, 0, 8'h81, 8'hA5, 8'hFF, 0, 32'h82);
        add(4, 32'h0,         0, 1, 8'h81, 8'hA5, 8'hFF, 1, 32'h83);
        add(7, 32'h0,         0, 1, 8'h81, 8'hA5, 8'hFF, 1, 32'h00);
        add(6, 32'hFFFFFFFF,  1, 0, 8'h81, 8'hA5, 8'hFF, 1, 32'h00);
        add(6, 32'h0,         0, 1, 8'h81, 8'hA5, 8'hFF, 1, 32'h00);
        add(1, 32'hFFFFFF3C,  1, 0, 8'h81, 8'h3C, 8'hFF, 1, 32'h00);
        add(1, 32'h0,         0, 1, 8'h81, 8'h3C, 8'hFF, 1, 32'h3C);

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].a, vt[i].d, vt[i].we, vt[i].re, vt[i].pins);
            chk($sformatf("vec%0d_o", i), {24'h0, gpio_o}, {24'h0, vt[i].e_o});
            chk($sformatf("vec%0d_oe", i), {24'h0, gpio_oe}, {24'h0, vt[i].e_oe});
            chk($sformatf("vec%0d_irq", i), {31'h0, irq}, {31'h0, vt[i].e_irq});
            chk($sformatf("vec%0d_rdata", i), bus_rdata, vt[i].e_rd);
        end

        begin
            logic [7:0] pins;
            pins = gpio_i;
            for (int n = 0; n < 400; n++) begin
                if ($urandom_range(3) == 0) pins = 8'($urandom);
                drive(3'($urandom), $urandom, 1'($urandom_range(3) == 0),
                      1'($urandom_range(1)), pins);
                chk($sformatf("rnd%0d_o", n), {24'h0, gpio_o}, {24'h0, m_out});
                chk($sformatf("rnd%0d_oe", n), {24'h0, gpio_oe}, {24'h0, m_dir});
                chk($sformatf("rnd%0d_irq", n), {31'h0, irq}, {31'h0, m_irq});
                chk($sformatf("rnd%0d_rdata", n), bus_rdata, m_rd);
            end
        end
`else
        repeat (2) drive(3'd0, 32'h0, 0, 0, 8'h08);
        repeat (12) drive(3'd0, 32'h0, 0, 0, 8'h00);
        drive(3'd0, 32'h0, 0, 1, 8'h00);
        chk("glitch_data_in", bus_rdata, 32'h0);
        drive(3'd4, 32'h0, 0, 1, 8'h00);
        chk("glitch_stat", bus_rdata, 32'h0);
        chk("glitch_irq", {31'h0, irq}, 32'h0);

        repeat (5) drive(3'd0, 32'h0, 0, 0, 8'h08);
        drive(3'd0, 32'h0, 0, 1, 8'h08);
        chk("dbnc_data_in_6clk", bus_rdata, 32'h0);
        drive(3'd0, 32'h0, 0, 1, 8'h08);
        chk("dbnc_data_in_7clk", bus_rdata, 32'h08);
        drive(3'd4, 32'h0, 0, 1, 8'h08);
        chk("dbnc_stat", bus_rdata, 32'h08);

        drive(3'd2, 32'h3C, 1, 0, 8'h08);
        chk("dbnc_dir_oe", {24'h0, gpio_oe}, 32'h3C);
        drive(3'd2, 32'h0, 0, 1, 8'h08);
        chk("dbnc_dir_read", bus_rdata, 32'h3C);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
